// File: rtl/palette_lut_bank_if.sv
// Pixel lookup, palette write and fade control bus for palette_lut_bank.
// The DUT takes the slave modport; the index fetch / CPU side takes master.
interface palette_lut_bank_if #(
    parameter int IDX_W   = 4,
    parameter int BANK_W  = 2,
    parameter int COLOR_W = 24,
    parameter int LEVEL_W = 4
);
    logic               i_pix_valid;
    logic [IDX_W-1:0]   i_pix_idx;
    logic [BANK_W-1:0]  i_pix_bank;
    logic               o_pix_valid;
    logic [COLOR_W-1:0] o_color;
    logic               o_transparent;

    logic               i_wr_en;
    logic [BANK_W-1:0]  i_wr_bank;
    logic [IDX_W-1:0]   i_wr_idx;
    logic [COLOR_W-1:0] i_wr_data;

    logic               i_fade_start;
    logic [LEVEL_W:0]   i_fade_target;
    logic [LEVEL_W:0]   o_level;
    logic               o_fade_busy;

    modport slave (
        input  i_pix_valid, i_pix_idx, i_pix_bank,
        output o_pix_valid, o_color, o_transparent,
        input  i_wr_en, i_wr_bank, i_wr_idx, i_wr_data,
        input  i_fade_start, i_fade_target,
        output o_level, o_fade_busy
    );

    modport master (
        output i_pix_valid, i_pix_idx, i_pix_bank,
        input  o_pix_valid, o_color, o_transparent,
        output i_wr_en, i_wr_bank, i_wr_idx, i_wr_data,
        output i_fade_start, i_fade_target,
        input  o_level, o_fade_busy
    );
endinterface

// File: rtl/palette_lut_bank.sv
// Multi-bank writable colour palette with a 2-stage lookup pipeline that
// scales each RGB channel by a brightness level driven by a fade FSM.
module palette_lut_bank #(
    parameter int IDX_W      = 4,
    parameter int BANKS      = 4,
    parameter int BANK_W     = 2,
    parameter int COLOR_W    = 24,
    parameter int TRANSP_IDX = 0,
    parameter int LEVEL_W    = 4,
    parameter int FADE_DIV   = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    palette_lut_bank_if.slave    bus
);
    localparam int ENTRIES = BANKS * (2 ** IDX_W);
    localparam int ADDR_W  = BANK_W + IDX_W;
    localparam int CH_W    = COLOR_W / 3;
    localparam int LVL_W   = LEVEL_W + 1;
    localparam int PROD_W  = CH_W + LVL_W;
    localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(2 ** LEVEL_W);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic {
        S_IDLE,
        S_FADING
    } state_t;

    logic [COLOR_W-1:0] mem_q [ENTRIES];
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;

    logic               v1_q;
    logic [COLOR_W-1:0] ent1_q;
    logic               transp1_q;
    logic [LVL_W-1:0]   lvl1_q;

    logic               pv2_q;
    logic [COLOR_W-1:0] color2_q;
    logic               transp2_q;
    logic [COLOR_W-1:0] scaled_c;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   target_q, target_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LVL_W-1:0]   tgt_clamp;

    assign wr_addr = {bus.i_wr_bank, bus.i_wr_idx};
    assign rd_addr = {bus.i_pix_bank, bus.i_pix_idx};

    // Palette storage; clearable on reset, so it lives in fabric registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.i_wr_en) begin
            mem_q[wr_addr] <= bus.i_wr_data;
        end
    end

    // Stage 1 samples the pre-write entry, so same-cycle read returns old data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q      <= 1'b0;
            ent1_q    <= '0;
            transp1_q <= 1'b0;
            lvl1_q    <= LVL_FULL;
        end else begin
            v1_q <= bus.i_pix_valid;
            if (bus.i_pix_valid) begin
                ent1_q    <= mem_q[rd_addr];
                transp1_q <= (bus.i_pix_idx == IDX_W'(TRANSP_IDX));
                lvl1_q    <= level_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign scaled_c[gi*CH_W +: CH_W] =
                CH_W'((PROD_W'(ent1_q[gi*CH_W +: CH_W]) * PROD_W'(lvl1_q)) >> LEVEL_W);
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pv2_q     <= 1'b0;
            color2_q  <= '0;
            transp2_q <= 1'b0;
        end else begin
            pv2_q <= v1_q;
            if (v1_q) begin
                color2_q  <= transp1_q ? '0 : scaled_c;
                transp2_q <= transp1_q;
            end
        end
    end

    assign bus.o_pix_valid   = pv2_q;
    assign bus.o_color       = color2_q;
    assign bus.o_transparent = transp2_q;

    assign tgt_clamp = (bus.i_fade_target > LVL_FULL) ? LVL_FULL : bus.i_fade_target;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            level_q  <= LVL_FULL;
            target_q <= LVL_FULL;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            div_q    <= div_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        div_d    = div_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_fade_start && (tgt_clamp != level_q)) begin
                    target_d = tgt_clamp;
                    div_d    = '0;
                    state_d  = S_FADING;
                end
            end
            S_FADING: begin
                if (bus.i_fade_start) begin
                    // Retarget keeps the current level and restarts the step timer.
                    target_d = tgt_clamp;
                    div_d    = '0;
                    if (tgt_clamp == level_q) begin
                        state_d = S_IDLE;
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    level_d = (target_q > level_q) ? (level_q + LVL_ONE) : (level_q - LVL_ONE);
                    if (level_d == target_q) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_level     = level_q;
    assign bus.o_fade_busy = (state_q == S_FADING);
endmodule

// File: tb/tb_palette_lut_bank.sv
// Directed bench for palette_lut_bank: table of write/lookup vectors plus
// hand sequences for pipelining, read-during-write, fades and mid-fade reset.
module tb_palette_lut_bank;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    palette_lut_bank_if #(.IDX_W(4), .BANK_W(2), .COLOR_W(24), .LEVEL_W(4)) bus ();

    palette_lut_bank #(
        .IDX_W(4), .BANKS(4), .BANK_W(2), .COLOR_W(24),
        .TRANSP_IDX(0), .LEVEL_W(4), .FADE_DIV(4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [1:0]  bank;
        logic [3:0]  idx;
        logic [23:0] data;
        logic [23:0] exp_color;
        logic        exp_transp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] i, input logic [23:0] d);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_bank = b;
        bus.i_wr_idx  = i;
        bus.i_wr_data = d;
        step();
        bus.i_wr_en = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [1:0] b, input logic [3:0] i,
                          input logic [23:0] ec, input logic et);
        bus.i_pix_valid = 1'b1;
        bus.i_pix_bank  = b;
        bus.i_pix_idx   = i;
        step();
        bus.i_pix_valid = 1'b0;
        chk({nm, ".lat1_valid"}, 32'(bus.o_pix_valid), 32'd0);
        step();
        chk({nm, ".valid"}, 32'(bus.o_pix_valid), 32'd1);
        chk({nm, ".color"}, 32'(bus.o_color), 32'(ec));
        chk({nm, ".transp"}, 32'(bus.o_transparent), 32'(et));
    endtask

    task automatic fade(input logic [4:0] t);
        bus.i_fade_start  = 1'b1;
        bus.i_fade_target = t;
        step();
        bus.i_fade_start = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;

        vecs[0] = '{1'b1, 2'd1, 4'd5,  24'h336699, 24'h336699, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 4'd0,  24'hFFFFFF, 24'h000000, 1'b1};
        vecs[2] = '{1'b0, 2'd2, 4'd0,  24'h000000, 24'h000000, 1'b1};
        vecs[3] = '{1'b1, 2'd2, 4'd3,  24'hFF8040, 24'hFF8040, 1'b0};
        vecs[4] = '{1'b1, 2'd3, 4'd15, 24'h000001, 24'h000001, 1'b0};
        vecs[5] = '{1'b1, 2'd3, 4'd7,  24'hABCDEF, 24'hABCDEF, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 4'd5,  24'h000000, 24'h000000, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 4'd0,  24'hAAAAAA, 24'h000000, 1'b1};

        rst_n = 1'b0;
        bus.i_pix_valid = 1'b0; bus.i_pix_idx = '0; bus.i_pix_bank = '0;
        bus.i_wr_en = 1'b0; bus.i_wr_bank = '0; bus.i_wr_idx = '0; bus.i_wr_data = '0;
        bus.i_fade_start = 1'b0; bus.i_fade_target = '0;

        step();
        chk("rst.valid",  32'(bus.o_pix_valid),   32'd0);
        chk("rst.color",  32'(bus.o_color),       32'd0);
        chk("rst.transp", 32'(bus.o_transparent), 32'd0);
        chk("rst.level",  32'(bus.o_level),       32'd16);
        chk("rst.busy",   32'(bus.o_fade_busy),   32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_wr) wr(vecs[v].bank, vecs[v].idx, vecs[v].data);
            lookup($sformatf("vec%0d", v), vecs[v].bank, vecs[v].idx,
                   vecs[v].exp_color, vecs[v].exp_transp);
        end

        // Back-to-back lookups, one per cycle, then hold after valid drops.
        bus.i_pix_valid = 1'b1; bus.i_pix_bank = 2'd1; bus.i_pix_idx = 4'd5;
        step();
        bus.i_pix_bank = 2'd0; bus.i_pix_idx = 4'd0;
        chk("b2b.lat1", 32'(bus.o_pix_valid), 32'd0);
        step();
        bus.i_pix_bank = 2'd3; bus.i_pix_idx = 4'd15;
        chk("b2b.a.color", 32'(bus.o_color), 32'h336699);
        step();
        bus.i_pix_valid = 1'b0;
        chk("b2b.b.color",  32'(bus.o_color), 32'h000000);
        chk("b2b.b.transp", 32'(bus.o_transparent), 32'd1);
        step();
        chk("b2b.c.color", 32'(bus.o_color), 32'h000001);
        chk("b2b.c.valid", 32'(bus.o_pix_valid), 32'd1);
        step();
        chk("hold.valid", 32'(bus.o_pix_valid), 32'd0);
        chk("hold.color", 32'(bus.o_color), 32'h000001);

        // Read-during-write returns old data; next-cycle read sees new data.
        bus.i_wr_en = 1'b1; bus.i_wr_bank = 2'd3; bus.i_wr_idx = 4'd7; bus.i_wr_data = 24'h123456;
        bus.i_pix_valid = 1'b1; bus.i_pix_bank = 2'd3; bus.i_pix_idx = 4'd7;
        step();
        bus.i_wr_en = 1'b0;
        step();
        bus.i_pix_valid = 1'b0;
        chk("rdw.old", 32'(bus.o_color), 32'hABCDEF);
        step();
        chk("rdw.new", 32'(bus.o_color), 32'h123456);

        // Clamped target equal to current level: no fade.
        fade(5'd20);
        chk("clamp.busy",  32'(bus.o_fade_busy), 32'd0);
        chk("clamp.level", 32'(bus.o_level), 32'd16);
        step(); step(); step();
        chk("clamp.level_later", 32'(bus.o_level), 32'd16);

        // Fade 16 -> 8: one step every 4 cycles, done after 32.
        fade(5'd8);
        chk("fade.busy",   32'(bus.o_fade_busy), 32'd1);
        chk("fade.level0", 32'(bus.o_level), 32'd16);
        n = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k == 3) chk("fade.level_k3", 32'(bus.o_level), 32'd16);
            if (k == 4) chk("fade.level_k4", 32'(bus.o_level), 32'd15);
            if (bus.o_level == 5'd8) begin
                n = k;
                break;
            end
        end
        chk("fade.cycles", 32'(n), 32'd32);
        chk("fade.busy_end", 32'(bus.o_fade_busy), 32'd0);
        lookup("lvl8.ff8040", 2'd2, 4'd3, 24'h7F4020, 1'b0);
        lookup("lvl8.336699", 2'd1, 4'd5, 24'h19334C, 1'b0);

        // Fade up, retarget to 12 at level 10.
        fade(5'd16);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.o_level == 5'd10) begin
                n = 1;
                break;
            end
            step();
        end
        chk("retgt.reach10", 32'(n), 32'd1);
        fade(5'd12);
        chk("retgt.keep_level", 32'(bus.o_level), 32'd10);
        chk("retgt.busy", 32'(bus.o_fade_busy), 32'd1);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.o_fade_busy) begin
                n = 1;
                break;
            end
            step();
        end
        chk("retgt.done", 32'(n), 32'd1);
        chk("retgt.level", 32'(bus.o_level), 32'd12);
        step(); step(); step(); step(); step();
        chk("retgt.stays", 32'(bus.o_level), 32'd12);

        // Retarget to the current level while fading ends the fade.
        fade(5'd0);
        chk("same.busy_on", 32'(bus.o_fade_busy), 32'd1);
        fade(5'd12);
        chk("same.busy_off", 32'(bus.o_fade_busy), 32'd0);
        chk("same.level", 32'(bus.o_level), 32'd12);

        // Reset in the middle of a fade with a pixel in flight.
        fade(5'd0);
        for (int k = 0; k < 6; k++) step();
        bus.i_pix_valid = 1'b1; bus.i_pix_bank = 2'd1; bus.i_pix_idx = 4'd5;
        step();
        bus.i_pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst.level", 32'(bus.o_level), 32'd16);
        chk("mrst.busy",  32'(bus.o_fade_busy), 32'd0);
        chk("mrst.valid", 32'(bus.o_pix_valid), 32'd0);
        chk("mrst.color", 32'(bus.o_color), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mrst.no_spurious", 32'(bus.o_pix_valid), 32'd0);
        lookup("mrst.b1i5", 2'd1, 4'd5, 24'h000000, 1'b0);
        lookup("mrst.b3i7", 2'd3, 4'd7, 24'h000000, 1'b0);
        chk("mrst.level_after", 32'(bus.o_level), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
